// File: rtl/bb_pe_acc_if.sv
`default_nettype none
// ============================================================================
//  Module      : bb_pe_acc_if
//  Description : Beat-in / result-out bundle for the bit-brick PE accumulator.
//                master = beat producer and result consumer
//                slave  = bb_pe_acc
//  Signals     : i_valid/o_ready/i_first/i_last   input beat handshake + framing
//                i_activation/i_weight             2 bits per brick
//                i_A_signed/i_W_signed             operand signedness flags
//                i_shift                           per-beat left shift
//                o_valid/i_ready                   result handshake
//                o_sum/o_ovf/o_count               group result
//  Revision    : 1.0 - initial release
// ============================================================================
interface bb_pe_acc_if #(
    parameter int N_BRICK = 16,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
);
    logic                      i_valid;
    logic                      o_ready;
    logic                      i_first;
    logic                      i_last;
    logic [2*N_BRICK-1:0]      i_activation;
    logic [2*N_BRICK-1:0]      i_weight;
    logic                      i_A_signed;
    logic                      i_W_signed;
    logic [SHIFT_W-1:0]        i_shift;
    logic                      o_valid;
    logic                      i_ready;
    logic signed [ACC_W-1:0]   o_sum;
    logic                      o_ovf;
    logic [CNT_W-1:0]          o_count;

    modport master (
        output i_valid, i_first, i_last, i_activation, i_weight,
               i_A_signed, i_W_signed, i_shift, i_ready,
        input  o_ready, o_valid, o_sum, o_ovf, o_count
    );

    modport slave (
        input  i_valid, i_first, i_last, i_activation, i_weight,
               i_A_signed, i_W_signed, i_shift, i_ready,
        output o_ready, o_valid, o_sum, o_ovf, o_count
    );
endinterface
`default_nettype wire

// File: rtl/bb_pe_acc.sv
`default_nettype none
// ============================================================================
//  Module      : bb_pe_acc
//  Description : Parametrised bit-brick processing element with group
//                accumulation. Each beat multiplies N_BRICK 2b x 2b brick
//                pairs, sums the products, shifts the sum left by i_shift
//                and accumulates it over a group framed by i_first/i_last.
//                Two pipeline stages: stage 1 registers the shifted brick
//                sum, stage 2 accumulates and loads the result registers.
//  Ports       : i_clk    clock
//                i_rst_n  asynchronous active-low reset
//                bus      bb_pe_acc_if.slave (beat in, group result out)
//  Config      : BB_PE_ACC_SAT_EN - when defined, the accumulator clamps to
//                the signed ACC_W range on overflow; otherwise it wraps.
//                o_ovf reports overflow in both builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module bb_pe_acc #(
    parameter int N_BRICK = 16,
    parameter int SHIFT_W = 3,
    parameter int ACC_W   = 24,
    parameter int CNT_W   = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    bb_pe_acc_if.slave   bus
);

    // Brick-sum width: 5b products, N_BRICK of them.
    localparam int c_SUM_W = 5 + $clog2(N_BRICK);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,     // no group open
        ST_ACC  = 1'b1      // group open, accumulator holds a partial sum
    } state_t;

    // ------------------------------------------------------------------
    // Declarations
    // ------------------------------------------------------------------
    state_t                 r_state;
    state_t                 w_state_next;

    logic                   w_stall;
    logic                   w_accept;

    logic signed [4:0]      w_prod [N_BRICK];
    logic [c_SUM_W-1:0]     w_brick_sum;
    logic [ACC_W-1:0]       w_beat_ext;
    logic [ACC_W-1:0]       w_beat;

    logic                   r_s1_valid;
    logic                   r_s1_first;
    logic                   r_s1_last;
    logic [ACC_W-1:0]       r_s1_beat;

    logic [ACC_W-1:0]       r_acc;
    logic [CNT_W-1:0]       r_cnt;
    logic                   r_ovf;

    logic                   w_start;
    logic [ACC_W-1:0]       w_base;
    logic [ACC_W-1:0]       w_add;
    logic                   w_step_ovf;
    logic [ACC_W-1:0]       w_acc_step;
    logic                   w_grp_ovf;
    logic [CNT_W-1:0]       w_grp_cnt;

    logic [ACC_W-1:0]       w_acc_next;
    logic [CNT_W-1:0]       w_cnt_next;
    logic                   w_ovf_next;
    logic                   w_emit;

    logic                   r_out_valid;
    logic [ACC_W-1:0]       r_out_sum;
    logic                   r_out_ovf;
    logic [CNT_W-1:0]       r_out_cnt;

`ifdef BB_PE_ACC_SAT_EN
    localparam logic [ACC_W-1:0] c_ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic [ACC_W-1:0] c_ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
`endif

    // ------------------------------------------------------------------
    // Handshake: a held result freezes the whole pipeline, so the input
    // side can only accept when the output register is free to move.
    // ------------------------------------------------------------------
    assign w_stall     = r_out_valid & ~bus.i_ready;
    assign w_accept    = bus.i_valid & ~w_stall;
    assign bus.o_ready = ~w_stall;

    // ------------------------------------------------------------------
    // Brick products. Operands are widened to 3b (sign or zero extended
    // by the per-beat flags) and multiplied at 6b; the product range
    // -6..9 always fits in the low 5 bits.
    // ------------------------------------------------------------------
    for (genvar k = 0; k < N_BRICK; k++) begin : g_brick
        logic [1:0]        w_a_raw;
        logic [1:0]        w_w_raw;
        logic signed [5:0] w_a6;
        logic signed [5:0] w_w6;
        logic signed [5:0] w_p6;

        assign w_a_raw = bus.i_activation[2*k+1:2*k];
        assign w_w_raw = bus.i_weight[2*k+1:2*k];
        assign w_a6    = {{4{bus.i_A_signed & w_a_raw[1]}}, w_a_raw};
        assign w_w6    = {{4{bus.i_W_signed & w_w_raw[1]}}, w_w_raw};
        assign w_p6    = w_a6 * w_w6;
        assign w_prod[k] = w_p6[4:0];
    end

    always_comb begin
        w_brick_sum = '0;
        for (int k = 0; k < N_BRICK; k++) begin
            w_brick_sum = w_brick_sum + {{(c_SUM_W-5){w_prod[k][4]}}, w_prod[k]};
        end
    end

    // Sign-extend to the accumulator width before shifting so the shift
    // never drops significant bits.
    assign w_beat_ext = {{(ACC_W-c_SUM_W){w_brick_sum[c_SUM_W-1]}}, w_brick_sum};
    assign w_beat     = w_beat_ext << bus.i_shift;

    // ------------------------------------------------------------------
    // Stage 1: registered beat value and framing flags
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_first <= 1'b0;
            r_s1_last  <= 1'b0;
            r_s1_beat  <= '0;
        end else if (!w_stall) begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_first <= bus.i_first;
                r_s1_last  <= bus.i_last;
                r_s1_beat  <= w_beat;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 datapath: one accumulate step for the beat in stage 1.
    // A beat arriving with no open group starts one, as does i_first.
    // ------------------------------------------------------------------
    always_comb begin
        w_start    = r_s1_first | (r_state == ST_IDLE);
        w_base     = w_start ? '0 : r_acc;
        w_add      = w_base + r_s1_beat;
        // Signed overflow: operands agree in sign, result does not.
        w_step_ovf = (w_base[ACC_W-1] == r_s1_beat[ACC_W-1]) &&
                     (w_add[ACC_W-1]  != w_base[ACC_W-1]);
`ifdef BB_PE_ACC_SAT_EN
        if (w_step_ovf) begin
            w_acc_step = w_base[ACC_W-1] ? c_ACC_MIN : c_ACC_MAX;
        end else begin
            w_acc_step = w_add;
        end
`else
        w_acc_step = w_add;
`endif
        w_grp_ovf = (~w_start & r_ovf) | w_step_ovf;
        if (w_start) begin
            w_grp_cnt = {{(CNT_W-1){1'b0}}, 1'b1};
        end else if (&r_cnt) begin
            w_grp_cnt = r_cnt;
        end else begin
            w_grp_cnt = r_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Group FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Group FSM: next state, accumulator update and emit decision
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_acc_next   = r_acc;
        w_cnt_next   = r_cnt;
        w_ovf_next   = r_ovf;
        w_emit       = 1'b0;

        if (r_s1_valid && !w_stall) begin
            if (r_s1_last) begin
                // Closing beat: publish the result and leave a clean slate.
                w_emit       = 1'b1;
                w_acc_next   = '0;
                w_cnt_next   = '0;
                w_ovf_next   = 1'b0;
                w_state_next = ST_IDLE;
            end else begin
                w_acc_next   = w_acc_step;
                w_cnt_next   = w_grp_cnt;
                w_ovf_next   = w_grp_ovf;
                w_state_next = ST_ACC;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_acc <= '0;
            r_cnt <= '0;
            r_ovf <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            r_cnt <= w_cnt_next;
            r_ovf <= w_ovf_next;
        end
    end

    // ------------------------------------------------------------------
    // Result registers. They only move when not stalled; a consumed
    // result with nothing new behind it drops o_valid on that edge.
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_out_valid <= 1'b0;
            r_out_sum   <= '0;
            r_out_ovf   <= 1'b0;
            r_out_cnt   <= '0;
        end else if (!w_stall) begin
            r_out_valid <= w_emit;
            if (w_emit) begin
                r_out_sum <= w_acc_step;
                r_out_ovf <= w_grp_ovf;
                r_out_cnt <= w_grp_cnt;
            end
        end
    end

    assign bus.o_valid = r_out_valid;
    assign bus.o_sum   = r_out_sum;
    assign bus.o_ovf   = r_out_ovf;
    assign bus.o_count = r_out_cnt;

endmodule
`default_nettype wire

// File: tb/tb_bb_pe_acc.sv
`default_nettype none
// ============================================================================
//  Module      : tb_bb_pe_acc
//  Description : Self-checking bench for bb_pe_acc. Two instances share one
//                stimulus stream: a 24-bit accumulator and a 16-bit one that
//                exercises overflow (wrap, or clamp with BB_PE_ACC_SAT_EN).
//                Expected results come from an arithmetic group model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_bb_pe_acc;
    localparam int N_BRICK = 16;
    localparam int SHIFT_W = 3;
    localparam int CNT_W   = 8;
    localparam int ACC_W_A = 24;
    localparam int ACC_W_B = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                 rst_n;
    logic                 d_valid, d_first, d_last, d_as, d_ws, d_ready;
    logic [2*N_BRICK-1:0] d_act, d_wt;
    logic [SHIFT_W-1:0]   d_shift;

    bb_pe_acc_if #(.N_BRICK(N_BRICK), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W_A), .CNT_W(CNT_W)) bus_a ();
    bb_pe_acc_if #(.N_BRICK(N_BRICK), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W_B), .CNT_W(CNT_W)) bus_b ();

    assign bus_a.i_valid = d_valid;      assign bus_b.i_valid = d_valid;
    assign bus_a.i_first = d_first;      assign bus_b.i_first = d_first;
    assign bus_a.i_last = d_last;        assign bus_b.i_last = d_last;
    assign bus_a.i_activation = d_act;   assign bus_b.i_activation = d_act;
    assign bus_a.i_weight = d_wt;        assign bus_b.i_weight = d_wt;
    assign bus_a.i_A_signed = d_as;      assign bus_b.i_A_signed = d_as;
    assign bus_a.i_W_signed = d_ws;      assign bus_b.i_W_signed = d_ws;
    assign bus_a.i_shift = d_shift;      assign bus_b.i_shift = d_shift;
    assign bus_a.i_ready = d_ready;      assign bus_b.i_ready = d_ready;

    bb_pe_acc #(.N_BRICK(N_BRICK), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W_A), .CNT_W(CNT_W)) u_dut_a (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_a));
    bb_pe_acc #(.N_BRICK(N_BRICK), .SHIFT_W(SHIFT_W), .ACC_W(ACC_W_B), .CNT_W(CNT_W)) u_dut_b (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus_b));

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input longint obs, input longint exp);
        total++;
        if (obs != exp) begin
            bad++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // ---------------- reference model ----------------
    typedef struct { longint sum; bit ovf; int cnt; } res_t;
    res_t   q_a[$];
    res_t   q_b[$];
    bit     m_open;
    longint m_acc [2];
    bit     m_ovf [2];
    int     m_cnt [2];

    bit     last_acc;
    int     acc_total;
    bit     prev_stall;
    longint prev_sum_a;

    function automatic longint beat_val(input logic [2*N_BRICK-1:0] act, input logic [2*N_BRICK-1:0] wt,
                                        input bit as, input bit ws, input int sh);
        longint s = 0;
        int av, wv;
        for (int k = 0; k < N_BRICK; k++) begin
            av = int'(act[2*k +: 2]);
            wv = int'(wt[2*k +: 2]);
            if (as && av >= 2) av -= 4;
            if (ws && wv >= 2) wv -= 4;
            s += longint'(av * wv);
        end
        return s * (longint'(1) << sh);
    endfunction

    task automatic model_acc(input int idx, input longint bv, input int w);
        longint hi, lo, n;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -hi - 1;
        n  = m_acc[idx] + bv;
        if (n > hi || n < lo) begin
            m_ovf[idx] = 1'b1;
`ifdef BB_PE_ACC_SAT_EN
            n = (n > hi) ? hi : lo;
`else
            n = n & ((longint'(1) << w) - 1);
            if (n > hi) n -= (longint'(1) << w);
`endif
        end
        m_acc[idx] = n;
        if (m_cnt[idx] < 255) m_cnt[idx]++;
    endtask

    task automatic model_beat(input bit f, input bit l, input longint bv);
        res_t r;
        if (!m_open || f) begin
            for (int i = 0; i < 2; i++) begin
                m_acc[i] = 0; m_ovf[i] = 0; m_cnt[i] = 0;
            end
        end
        model_acc(0, bv, ACC_W_A);
        model_acc(1, bv, ACC_W_B);
        if (l) begin
            r.sum = m_acc[0]; r.ovf = m_ovf[0]; r.cnt = m_cnt[0]; q_a.push_back(r);
            r.sum = m_acc[1]; r.ovf = m_ovf[1]; r.cnt = m_cnt[1]; q_b.push_back(r);
            m_open = 1'b0;
        end else begin
            m_open = 1'b1;
        end
    endtask

    // ---------------- one clock of stimulus + checks ----------------
    // Entered at a negedge with inputs applied; returns at the next negedge.
    task automatic cycle();
        res_t r;
        #1;
        chk("ready_rule", bus_a.o_ready, (bus_a.o_valid && !d_ready) ? 0 : 1);
        if (bus_a.o_valid && d_ready) begin
            if (q_a.size() == 0) chk("pending_a", q_a.size(), 1);
            else begin
                r = q_a.pop_front();
                chk("sum_a", bus_a.o_sum, r.sum);
                chk("ovf_a", bus_a.o_ovf, r.ovf);
                chk("cnt_a", bus_a.o_count, r.cnt);
            end
        end
        if (bus_b.o_valid && d_ready) begin
            if (q_b.size() == 0) chk("pending_b", q_b.size(), 1);
            else begin
                r = q_b.pop_front();
                chk("sum_b", bus_b.o_sum, r.sum);
                chk("ovf_b", bus_b.o_ovf, r.ovf);
                chk("cnt_b", bus_b.o_count, r.cnt);
            end
        end
        last_acc = d_valid && bus_a.o_ready;
        if (last_acc) begin
            acc_total++;
            model_beat(d_first, d_last, beat_val(d_act, d_wt, d_as, d_ws, int'(d_shift)));
        end
        prev_stall = bus_a.o_valid && !d_ready;
        prev_sum_a = bus_a.o_sum;
        @(posedge clk);
        @(negedge clk);
        if (prev_stall) begin
            chk("stall_valid", bus_a.o_valid, 1);
            chk("stall_sum", bus_a.o_sum, prev_sum_a);
        end
    endtask

    task automatic set_beat(input bit f, input bit l, input logic [31:0] act, input logic [31:0] wt,
                            input bit as, input bit ws, input int sh);
        d_valid = 1'b1; d_first = f; d_last = l;
        d_act = act; d_wt = wt; d_as = as; d_ws = ws;
        d_shift = SHIFT_W'(sh);
    endtask

    task automatic send(input bit f, input bit l, input logic [31:0] act, input logic [31:0] wt,
                        input bit as, input bit ws, input int sh, input bit rnd);
        int tries = 0;
        set_beat(f, l, act, wt, as, ws, sh);
        last_acc = 1'b0;
        while (!last_acc && tries < 100) begin
            if (rnd) d_ready = ($urandom_range(3) != 0);
            cycle();
            tries++;
        end
        if (!last_acc) chk("accept_timeout", last_acc, 1);
        d_valid = 1'b0;
    endtask

    task automatic idle();
        d_valid = 1'b0;
        cycle();
    endtask

    task automatic do_reset();
        d_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("rst_valid", bus_a.o_valid, 0);
        chk("rst_sum", bus_a.o_sum, 0);
        chk("rst_ovf", bus_a.o_ovf, 0);
        chk("rst_count", bus_a.o_count, 0);
        chk("rst_ready", bus_a.o_ready, 1);
        m_open = 1'b0;
        q_a.delete();
        q_b.delete();
        prev_stall = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    longint exp_b;
    int     base_cnt;

    initial begin
        rst_n = 1'b0;
        d_valid = 0; d_first = 0; d_last = 0; d_act = '0; d_wt = '0;
        d_as = 0; d_ws = 0; d_shift = '0; d_ready = 1'b1;
        m_open = 0; acc_total = 0; prev_stall = 0; prev_sum_a = 0; last_acc = 0;
        @(negedge clk);
        do_reset();

        // 1: all-ones unsigned single-beat group, latency check
        send(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        chk("t1_valid_e0", bus_a.o_valid, 0);
        idle();
        chk("t1_valid_e1", bus_a.o_valid, 1);
        chk("t1_sum", bus_a.o_sum, 144);
        chk("t1_count", bus_a.o_count, 1);
        chk("t1_ovf", bus_a.o_ovf, 0);

        // 2: signedness and shift
        send(1, 1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 1, 0, 0); idle();
        chk("t2_ss", bus_a.o_sum, 64);
        send(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 0, 0); idle();
        chk("t2_neg", bus_a.o_sum, -32);
        send(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 4, 0); idle();
        chk("t2_shift4", bus_a.o_sum, -512);
        send(1, 1, 32'hFFFF_FFFF, 32'hAAAA_AAAA, 0, 1, 0, 0); idle();
        chk("t2_mixed", bus_a.o_sum, -96);

        // 3: three-beat group
        send(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        send(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 2, 0);
        send(0, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 0, 0);
        idle();
        chk("t3_sum", bus_a.o_sum, 688);
        chk("t3_count", bus_a.o_count, 3);
        idle();
        chk("t3_pulse", bus_a.o_valid, 0);

        // 4: back-pressure while beats keep coming
        base_cnt = acc_total;
        d_ready = 1'b0;
        send(1, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        send(1, 1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 1, 0, 0);
        set_beat(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 0);
        for (int i = 0; i < 5; i++) begin
            cycle();
            chk("t4_no_take", last_acc, 0);
            chk("t4_ready_low", bus_a.o_ready, 0);
        end
        chk("t4_held_sum", bus_a.o_sum, 144);
        d_ready = 1'b1;
        send(1, 1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1, 0, 0);
        repeat (4) idle();
        chk("t4_beats", acc_total - base_cnt, 3);

        // 5: overflow on the 16-bit instance
        send(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 7, 0);
        send(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 7, 0);
        idle();
`ifdef BB_PE_ACC_SAT_EN
        exp_b = 32767;
`else
        exp_b = -28672;
`endif
        chk("t5_sum_a", bus_a.o_sum, 36864);
        chk("t5_ovf_a", bus_a.o_ovf, 0);
        chk("t5_sum_b", bus_b.o_sum, exp_b);
        chk("t5_ovf_b", bus_b.o_ovf, 1);
        idle();

        // 6: reset mid-group, last-only beat from IDLE, restart mid-group
        send(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        send(0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        do_reset();
        for (int i = 0; i < 3; i++) begin
            idle();
            chk("t6_no_valid", bus_a.o_valid, 0);
        end
        send(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0); idle();
        chk("t6_lastonly_cnt", bus_a.o_count, 1);
        chk("t6_lastonly_sum", bus_a.o_sum, 144);
        send(1, 0, 32'h5555_5555, 32'h5555_5555, 0, 0, 0, 0);
        send(0, 0, 32'h5555_5555, 32'h5555_5555, 0, 0, 0, 0);
        send(1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0, 0, 0);
        send(0, 1, 32'hAAAA_AAAA, 32'hAAAA_AAAA, 1, 1, 0, 0); idle();
        chk("t6_restart_sum", bus_a.o_sum, 208);
        chk("t6_restart_cnt", bus_a.o_count, 2);

        // beat counter saturation
        for (int i = 0; i < 300; i++)
            send(i == 0, i == 299, 32'h5555_5555, 32'h5555_5555, 0, 0, 0, 0);
        idle();
        chk("cnt_sat", bus_a.o_count, 255);
        chk("cnt_sat_sum", bus_a.o_sum, 4800);

        // randomized traffic with random back-pressure
        for (int i = 0; i < 400; i++) begin
            send($urandom_range(5) == 0, $urandom_range(3) == 0, $urandom, $urandom,
                 $urandom_range(1) == 1, $urandom_range(1) == 1, int'($urandom_range(7)), 1);
            if ($urandom_range(4) == 0) idle();
        end
        send(0, 1, $urandom, $urandom, 0, 0, 0, 1);
        d_ready = 1'b1;
        repeat (6) idle();
        chk("drain_a", q_a.size(), 0);
        chk("drain_b", q_b.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
`default_nettype wire
